// File: rtl/conv_ctrl_pkg.sv
// Shared types and helpers for the convolution row read-side controller.
package conv_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        WAIT_FULL,
        READ,
        DRAIN,
        DONE,
        ERR
    } seq_state_t;

    // A job is runnable only with a non-empty row that fits the buffer and at least one row.
    function automatic logic cfg_ok(input logic [31:0] width,
                                    input logic [31:0] rows,
                                    input logic [31:0] max_width);
        return (width != 32'd0) && (width <= max_width) && (rows != 32'd0);
    endfunction

endpackage

// File: rtl/seq_skid_fifo.sv
// Small synchronous FIFO that absorbs buffer read data while the stream is stalled.
module seq_skid_fifo #(
    parameter int unsigned WIDTH = 97,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage write; contents need no reset because empty masks them.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= next_ptr(wr_ptr);
            if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/conv_row_sequencer.sv
// Read-side controller for the 3-row line buffer: issues credited column reads once the
// buffer is full, tags the last column of each row, and streams columns out through a skid FIFO.
// Optional feature: define CONV_SEQ_STATS_EN to add the stall_cycles counter output.
module conv_row_sequencer
    import conv_ctrl_pkg::*;
#(
    parameter int unsigned BUS_WIDTH     = 32,
    parameter int unsigned ROWS          = 3,
    parameter int unsigned MAX_ROW_WIDTH = 1024,
    parameter int unsigned ADDR_WIDTH    = $clog2(MAX_ROW_WIDTH),
    parameter int unsigned READ_LATENCY  = 2,
    parameter int unsigned SKID_DEPTH    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [31:0]               row_width,
    input  logic [31:0]               num_rows,
    input  logic                      buf_full,
    input  logic                      buf_valid,
    input  logic [ROWS*BUS_WIDTH-1:0] buf_data,
    output logic [ADDR_WIDTH-1:0]     rd_addr,
    output logic                      rd_en,
    output logic [ROWS*BUS_WIDTH-1:0] m_tdata,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic                      m_tlast,
    output logic                      busy,
    output logic                      done,
    output logic                      err
`ifdef CONV_SEQ_STATS_EN
    ,
    output logic [31:0]               stall_cycles
`endif
);

    localparam int unsigned DATA_W = ROWS * BUS_WIDTH;
    localparam int unsigned CNT_W  = $clog2(SKID_DEPTH + 1);

    seq_state_t              state;
    seq_state_t              state_next;
    logic [31:0]             cfg_width;
    logic [31:0]             cfg_rows;
    logic [31:0]             rows_done;
    logic [ADDR_WIDTH:0]     col;
    logic [CNT_W-1:0]        outstanding;
    logic [CNT_W-1:0]        fifo_count;
    logic [READ_LATENCY-1:0] tag_pipe;
    logic                    hold;
    logic                    credit;
    logic                    issue;
    logic                    last_col;
    logic                    accept;
    logic                    pop;
    logic                    fifo_empty;
    logic [DATA_W:0]         fifo_head;

    assign credit   = (32'(outstanding) + 32'(fifo_count)) < SKID_DEPTH;
    assign issue    = (state == READ) && credit;
    assign last_col = (32'(col) == cfg_width - 32'd1);
    assign accept   = buf_valid && (outstanding != '0);
    assign pop      = m_tvalid && m_tready;

    assign rd_en    = issue;
    assign rd_addr  = issue ? col[ADDR_WIDTH-1:0] : '0;
    assign m_tvalid = !fifo_empty;
    assign m_tdata  = m_tvalid ? fifo_head[DATA_W:1] : '0;
    assign m_tlast  = m_tvalid && fifo_head[0];
    assign busy     = (state == CHECK) || (state == WAIT_FULL) || (state == READ) || (state == DRAIN);
    assign done     = (state == DONE) || (state == ERR);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic; DRAIN leaves as the final beat pops so done lands the cycle after it.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (start) state_next = CHECK;
            CHECK:     state_next = cfg_ok(cfg_width, cfg_rows, 32'(MAX_ROW_WIDTH)) ? WAIT_FULL : ERR;
            WAIT_FULL: if (!hold && buf_full) state_next = READ;
            READ: begin
                if (issue && last_col) begin
                    state_next = (rows_done + 32'd1 < cfg_rows) ? WAIT_FULL : DRAIN;
                end
            end
            DRAIN: begin
                if ((outstanding == '0) &&
                    ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop))) begin
                    state_next = DONE;
                end
            end
            DONE:      state_next = IDLE;
            ERR:       state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Job configuration, column/row counters, read credit and the error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_width   <= '0;
            cfg_rows    <= '0;
            rows_done   <= '0;
            col         <= '0;
            outstanding <= '0;
            hold        <= 1'b0;
            err         <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                cfg_width <= row_width;
                cfg_rows  <= num_rows;
                rows_done <= '0;
                col       <= '0;
                err       <= 1'b0;
            end
            if (state == CHECK && state_next == ERR) err <= 1'b1;
            if (issue) begin
                col <= last_col ? '0 : col + 1'b1;
                if (last_col) rows_done <= rows_done + 32'd1;
            end
            hold        <= (state == READ) && (state_next == WAIT_FULL);
            outstanding <= outstanding + CNT_W'(issue) - CNT_W'(accept);
        end
    end

    // Last-column tag travels alongside each read for the buffer's fixed latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_pipe <= '0;
        end else begin
            tag_pipe[0] <= issue && last_col;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    seq_skid_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (SKID_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (accept),
        .wr_data ({buf_data, tag_pipe[READ_LATENCY-1]}),
        .pop     (pop),
        .rd_data (fifo_head),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

`ifdef CONV_SEQ_STATS_EN
    logic stall;
    assign stall = busy && ((state == WAIT_FULL) || ((state == READ) && !credit) || (m_tvalid && !m_tready));

    // Saturating stall counter, restarted by each accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (state == IDLE && start) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_row_sequencer.sv
// Self-checking bench for conv_row_sequencer with a behavioural line-buffer responder.
module tb_conv_row_sequencer;

    localparam int unsigned BW = 32;
    localparam int unsigned NR = 3;
    localparam int unsigned AW = 10;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [31:0]     row_width = '0;
    logic [31:0]     num_rows = '0;
    logic            buf_full = 1'b0;
    logic            buf_valid;
    logic [NR*BW-1:0] buf_data;
    logic [AW-1:0]   rd_addr;
    logic            rd_en;
    logic [NR*BW-1:0] m_tdata;
    logic            m_tvalid;
    logic            m_tready = 1'b0;
    logic            m_tlast;
    logic            busy;
    logic            done;
    logic            err;
`ifdef CONV_SEQ_STATS_EN
    logic [31:0]     stall_cycles;
`endif

    conv_row_sequencer #(
        .BUS_WIDTH     (BW),
        .ROWS          (NR),
        .MAX_ROW_WIDTH (1024),
        .ADDR_WIDTH    (AW),
        .READ_LATENCY  (2),
        .SKID_DEPTH    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .row_width (row_width),
        .num_rows  (num_rows),
        .buf_full  (buf_full),
        .buf_valid (buf_valid),
        .buf_data  (buf_data),
        .rd_addr   (rd_addr),
        .rd_en     (rd_en),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tlast   (m_tlast),
        .busy      (busy),
        .done      (done),
        .err       (err)
`ifdef CONV_SEQ_STATS_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned fails  = 0;

    // Line buffer model: fixed 2-cycle read latency; data encodes address, seed and read sequence.
    logic          p0 = 1'b0, p1 = 1'b0, inject = 1'b0;
    logic [AW-1:0] a0 = '0, a1 = '0;
    logic [31:0]   s0r = '0, s1r = '0, rd_seq = '0, seed = '0;
    always @(posedge clk) begin
        p0 <= rd_en; a0 <= rd_addr; s0r <= rd_seq;
        p1 <= p0;    a1 <= a0;      s1r <= s0r;
        if (rd_en) rd_seq <= rd_seq + 32'd1;
    end
    assign buf_valid = p1 | inject;
    assign buf_data  = {seed ^ 32'(a1), s1r, ~seed + 32'(a1)};

    // Observation recorder, sampled on the falling edge.
    int unsigned  rd_q[$];
    longint       rdcyc_q[$];
    logic [96:0]  beat_q[$];
    longint       beatcyc_q[$];
    longint       cyc = 0;
    int unsigned  done_cnt = 0, viol = 0, stall_ref = 0;
    logic         pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [95:0]  pd = '0;
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (rd_en) begin rd_q.push_back(32'(rd_addr)); rdcyc_q.push_back(cyc); end
            if (m_tvalid && m_tready) begin beat_q.push_back({m_tlast, m_tdata}); beatcyc_q.push_back(cyc); end
            if (done) done_cnt++;
            if (pv && !pr && (m_tvalid !== 1'b1 || m_tdata !== pd || m_tlast !== pl)) viol++;
            if (busy && m_tvalid && !m_tready) stall_ref++;
        end
        pv = m_tvalid && !rst; pr = m_tready; pd = m_tdata; pl = m_tlast;
    end

    // Job bookkeeping for the reference model.
    int unsigned job_w, rb, bb, db, vb, sb;
    logic [31:0] job_seed, job_s0;

    // Expected k-th beat of a job: column k mod w of read number k, last on the final column.
    function automatic logic [96:0] exp_beat(input int unsigned k, input int unsigned w,
                                             input logic [31:0] sd, input logic [31:0] s0);
        int unsigned a;
        a = k % w;
        return {(a == w - 1), sd ^ a, s0 + k, ~sd + a};
    endfunction

    task automatic job_begin(input int unsigned w);
        job_w = w; job_seed = $urandom; seed = job_seed; job_s0 = rd_seq;
        rb = rd_q.size(); bb = beat_q.size(); db = done_cnt; vb = viol; sb = stall_ref;
    endtask

    task automatic pulse_start(input int unsigned w, input int unsigned n);
        @(posedge clk); #1;
        row_width = w; num_rows = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_job(input int unsigned w, input int unsigned n, input int unsigned rdy_pct,
                           input int unsigned full_pct, input int unsigned max_cyc, output bit timed_out);
        job_begin(w);
        m_tready = (rdy_pct >= 100);
        buf_full = (full_pct >= 100);
        pulse_start(w, n);
        timed_out = 1'b1;
        for (int unsigned i = 0; i < max_cyc; i++) begin
            @(posedge clk); #1;
            m_tready = ($urandom_range(99) < rdy_pct);
            buf_full = ($urandom_range(99) < full_pct);
            @(negedge clk);
            if (done) begin timed_out = 1'b0; break; end
        end
        @(posedge clk); #1;
        m_tready = 1'b0;
    endtask

    task automatic test_reset();
        logic [111:0] ov;
        @(negedge clk);
        ov = {rd_en, rd_addr, m_tvalid, m_tlast, busy, done, err, m_tdata};
        checks++;
        if (ov !== '0) begin fails++; $display("FAIL reset_outputs: got %0h expected 0", ov); end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        bit to;
        run_job(4, 2, 100, 100, 200, to);
        checks++; if (to) begin fails++; $display("FAIL basic_timeout: done=0 expected 1"); end
        checks++;
        if (rd_q.size() - rb != 8) begin fails++; $display("FAIL basic_reads: got %0d expected 8", rd_q.size() - rb); end
        checks++;
        if (beat_q.size() - bb != 8) begin fails++; $display("FAIL basic_beats: got %0d expected 8", beat_q.size() - bb); end
        if (rd_q.size() >= rb + 8 && beat_q.size() >= bb + 8) begin
            for (int unsigned i = 0; i < 8; i++) begin
                checks++;
                if (rd_q[rb+i] != i % 4) begin fails++; $display("FAIL basic_addr[%0d]: got %0d expected %0d", i, rd_q[rb+i], i % 4); end
                checks++;
                if (beat_q[bb+i] !== exp_beat(i, 4, job_seed, job_s0)) begin
                    fails++; $display("FAIL basic_beat[%0d]: got %h expected %h", i, beat_q[bb+i], exp_beat(i, 4, job_seed, job_s0));
                end
            end
            checks++;
            if (beatcyc_q[bb] - rdcyc_q[rb] != 3) begin
                fails++; $display("FAIL first_beat_latency: got %0d expected 3", beatcyc_q[bb] - rdcyc_q[rb]);
            end
            checks++;
            if (rdcyc_q[rb+4] - rdcyc_q[rb+3] != 3) begin
                fails++; $display("FAIL row_gap: got %0d expected 3", rdcyc_q[rb+4] - rdcyc_q[rb+3]);
            end
        end
        checks++;
        if (done_cnt - db != 1) begin fails++; $display("FAIL basic_done: got %0d expected 1", done_cnt - db); end
        checks++;
        if (busy !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL basic_idle: busy=%b err=%b expected 0 0", busy, err); end
    endtask

    task automatic test_backpressure();
        bit to;
        job_begin(8);
        m_tready = 1'b0; buf_full = 1'b1;
        pulse_start(8, 1);
        repeat (30) @(negedge clk);
        @(posedge clk); #1;
        checks++;
        if (rd_q.size() - rb != 4 || rd_en !== 1'b0) begin
            fails++; $display("FAIL stall_reads: got %0d rd_en=%b expected 4 0", rd_q.size() - rb, rd_en);
        end
        checks++;
        if (m_tvalid !== 1'b1) begin fails++; $display("FAIL stall_valid: got %b expected 1", m_tvalid); end
        to = 1'b1;
        for (int unsigned i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            m_tready = ($urandom_range(1) == 1);
            @(negedge clk);
            if (done) begin to = 1'b0; break; end
        end
        @(posedge clk); #1;
        m_tready = 1'b0;
        checks++; if (to) begin fails++; $display("FAIL bp_timeout: done=0 expected 1"); end
        checks++;
        if (beat_q.size() - bb != 8) begin fails++; $display("FAIL bp_beats: got %0d expected 8", beat_q.size() - bb); end
        else begin
            for (int unsigned i = 0; i < 8; i++) begin
                checks++;
                if (beat_q[bb+i] !== exp_beat(i, 8, job_seed, job_s0)) begin
                    fails++; $display("FAIL bp_beat[%0d]: got %h expected %h", i, beat_q[bb+i], exp_beat(i, 8, job_seed, job_s0));
                end
            end
        end
        checks++;
        if (viol - vb != 0) begin fails++; $display("FAIL bp_stable: got %0d changes expected 0", viol - vb); end
`ifdef CONV_SEQ_STATS_EN
        checks++;
        if (stall_cycles < stall_ref - sb) begin
            fails++; $display("FAIL stall_count: got %0d expected >= %0d", stall_cycles, stall_ref - sb);
        end
`endif
    endtask

    task automatic test_wait_full();
        bit to;
        job_begin(6);
        m_tready = 1'b1; buf_full = 1'b1;
        pulse_start(6, 2);
        for (int unsigned i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rd_en && rd_addr == 10'd5) begin buf_full = 1'b0; break; end
        end
        repeat (10) @(negedge clk);
        @(posedge clk); #1;
        checks++;
        if (rd_q.size() - rb != 6 || rd_en !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL wait_full_hold: reads=%0d rd_en=%b busy=%b expected 6 0 1", rd_q.size() - rb, rd_en, busy);
        end
        buf_full = 1'b1;
        to = 1'b1;
        for (int unsigned i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin to = 1'b0; break; end
        end
        @(posedge clk); #1;
        checks++; if (to) begin fails++; $display("FAIL wf_timeout: done=0 expected 1"); end
        checks++;
        if (rd_q.size() - rb != 12) begin fails++; $display("FAIL wf_reads: got %0d expected 12", rd_q.size() - rb); end
        else begin
            checks++;
            if (rd_q[rb+6] != 0) begin fails++; $display("FAIL wf_resume_addr: got %0d expected 0", rd_q[rb+6]); end
        end
        checks++;
        if (beat_q.size() - bb != 12) begin fails++; $display("FAIL wf_beats: got %0d expected 12", beat_q.size() - bb); end
        else begin
            for (int unsigned i = 0; i < 12; i++) begin
                checks++;
                if (beat_q[bb+i] !== exp_beat(i, 6, job_seed, job_s0)) begin
                    fails++; $display("FAIL wf_beat[%0d]: got %h expected %h", i, beat_q[bb+i], exp_beat(i, 6, job_seed, job_s0));
                end
            end
        end
    endtask

    task automatic test_bad_cfg();
        int unsigned ws[3] = '{0, 1025, 5};
        int unsigned ns[3] = '{3, 2, 0};
        bit to;
        for (int unsigned t = 0; t < 3; t++) begin
            job_begin(1);
            buf_full = 1'b1; m_tready = 1'b1;
            pulse_start(ws[t], ns[t]);
            repeat (6) @(negedge clk);
            @(posedge clk); #1;
            checks++;
            if (err !== 1'b1 || done_cnt - db != 1 || rd_q.size() != rb || busy !== 1'b0) begin
                fails++; $display("FAIL bad_cfg[%0d]: err=%b dones=%0d reads=%0d busy=%b expected 1 1 0 0",
                                  t, err, done_cnt - db, rd_q.size() - rb, busy);
            end
        end
        run_job(1, 1, 100, 100, 50, to);
        checks++;
        if (to || err !== 1'b0) begin fails++; $display("FAIL err_clear: timeout=%b err=%b expected 0 0", to, err); end
        checks++;
        if (beat_q.size() - bb != 1 || beat_q[beat_q.size()-1] !== exp_beat(0, 1, job_seed, job_s0)) begin
            fails++; $display("FAIL width1_beat: count=%0d expected 1 with last set", beat_q.size() - bb);
        end
        run_job(1024, 1, 100, 100, 1300, to);
        checks++;
        if (to || rd_q.size() - rb != 1024 || beat_q.size() - bb != 1024) begin
            fails++; $display("FAIL max_width: timeout=%b reads=%0d beats=%0d expected 0 1024 1024", to, rd_q.size() - rb, beat_q.size() - bb);
        end else begin
            for (int unsigned i = 0; i < 1024; i++) begin
                checks++;
                if (beat_q[bb+i] !== exp_beat(i, 1024, job_seed, job_s0) || rd_q[rb+i] != i) begin
                    fails++; $display("FAIL max_width_beat[%0d]: got %h expected %h", i, beat_q[bb+i], exp_beat(i, 1024, job_seed, job_s0));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [111:0] ov;
        bit to;
        bit hit;
        job_begin(16);
        m_tready = 1'b1; buf_full = 1'b1;
        pulse_start(16, 1);
        hit = 1'b0;
        for (int unsigned i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rd_en && rd_addr == 10'd7) begin hit = 1'b1; break; end
        end
        rst = 1'b1;
        #1;
        ov = {rd_en, rd_addr, m_tvalid, m_tlast, busy, done, err, m_tdata};
        checks++;
        if (!hit || ov !== '0) begin fails++; $display("FAIL reset_mid: reached=%b outputs=%0h expected 1 0", hit, ov); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        inject = 1'b1;
        repeat (2) @(posedge clk);
        #1; inject = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (m_tvalid !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL stray_valid: m_tvalid=%b busy=%b expected 0 0", m_tvalid, busy);
        end
        run_job(5, 1, 100, 100, 100, to);
        checks++;
        if (to || rd_q.size() - rb != 5 || beat_q.size() - bb != 5) begin
            fails++; $display("FAIL post_reset_job: timeout=%b reads=%0d beats=%0d expected 0 5 5", to, rd_q.size() - rb, beat_q.size() - bb);
        end else begin
            for (int unsigned i = 0; i < 5; i++) begin
                checks++;
                if (rd_q[rb+i] != i || beat_q[bb+i] !== exp_beat(i, 5, job_seed, job_s0)) begin
                    fails++; $display("FAIL post_reset[%0d]: addr=%0d beat=%h expected %0d %h", i, rd_q[rb+i], beat_q[bb+i], i, exp_beat(i, 5, job_seed, job_s0));
                end
            end
        end
    endtask

    task automatic test_start_busy();
        bit to;
        job_begin(6);
        m_tready = 1'b0; buf_full = 1'b1;
        pulse_start(6, 1);
        repeat (3) @(negedge clk);
        pulse_start(3, 5);
        m_tready = 1'b1;
        to = 1'b1;
        for (int unsigned i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin to = 1'b0; break; end
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (to || done_cnt - db != 1 || rd_q.size() - rb != 6 || busy !== 1'b0) begin
            fails++; $display("FAIL start_busy: timeout=%b dones=%0d reads=%0d busy=%b expected 0 1 6 0", to, done_cnt - db, rd_q.size() - rb, busy);
        end
        checks++;
        if (beat_q.size() - bb != 6) begin fails++; $display("FAIL start_busy_beats: got %0d expected 6", beat_q.size() - bb); end
        else begin
            for (int unsigned i = 0; i < 6; i++) begin
                checks++;
                if (beat_q[bb+i] !== exp_beat(i, 6, job_seed, job_s0)) begin
                    fails++; $display("FAIL start_busy_beat[%0d]: got %h expected %h", i, beat_q[bb+i], exp_beat(i, 6, job_seed, job_s0));
                end
            end
        end
        m_tready = 1'b0;
    endtask

    task automatic test_random();
        bit to;
        int unsigned w, n;
        for (int unsigned j = 0; j < 6; j++) begin
            w = $urandom_range(20, 1);
            n = $urandom_range(3, 1);
            run_job(w, n, 60, 70, 3000, to);
            checks++;
            if (to || done_cnt - db != 1 || viol != vb) begin
                fails++; $display("FAIL rand_job[%0d]: timeout=%b dones=%0d unstable=%0d expected 0 1 0", j, to, done_cnt - db, viol - vb);
            end
            checks++;
            if (rd_q.size() - rb != w * n || beat_q.size() - bb != w * n) begin
                fails++; $display("FAIL rand_count[%0d]: reads=%0d beats=%0d expected %0d", j, rd_q.size() - rb, beat_q.size() - bb, w * n);
            end else begin
                for (int unsigned i = 0; i < w * n; i++) begin
                    checks++;
                    if (rd_q[rb+i] != i % w || beat_q[bb+i] !== exp_beat(i, w, job_seed, job_s0)) begin
                        fails++; $display("FAIL rand_beat[%0d][%0d]: addr=%0d beat=%h expected %0d %h", j, i, rd_q[rb+i], beat_q[bb+i], i % w, exp_beat(i, w, job_seed, job_s0));
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wait_full();
        test_bad_cfg();
        test_reset_mid();
        test_start_busy();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
